// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin set/reset command arbiter for a shared SR flip-flop bank
module sr_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       op,
  input  logic [N_REQ*IDX_W-1:0] idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       S,
  output logic [WIDTH-1:0]       R,
  output logic [WIDTH-1:0]       shadow,
  output logic                   busy,
  output logic                   err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic             lat_op;
  logic [WIDTH-1:0] lat_mask;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand;
  logic             win_op;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [WIDTH-1:0] win_mask;
  logic [PTR_W-1:0] ptr_next;

  // Round-robin search: first asserted req at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Decode the winner's command into a one-hot bit mask; out-of-range index gives an empty mask.
  always_comb begin
    win_op    = op[win];
    win_idx   = idx[int'(win)*IDX_W +: IDX_W];
    win_valid = (int'(win_idx) < WIDTH);
    win_mask  = win_valid ? (WIDTH'(1) << win_idx) : '0;
    ptr_next  = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  end

  // Four-phase sequencer: INIT clears the bank, IDLE arbitrates, DRIVE pulses S/R, HOLD guards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      ptr      <= '0;
      gnt      <= '0;
      S        <= '0;
      R        <= '1;
      shadow   <= '0;
      busy     <= 1'b1;
      err      <= 1'b0;
      lat_op   <= 1'b0;
      lat_mask <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          R     <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (found) begin
            gnt      <= N_REQ'(1) << win;
            busy     <= 1'b1;
            S        <= win_op ? win_mask : '0;
            R        <= win_op ? '0 : win_mask;
            err      <= !win_valid;
            lat_op   <= win_op;
            lat_mask <= win_mask;
            ptr      <= ptr_next;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          shadow <= lat_op ? (shadow | lat_mask) : (shadow & ~lat_mask);
          gnt    <= '0;
          S      <= '0;
          R      <= '0;
          err    <= 1'b0;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - randomized self-checking bench for sr_bank_arbiter with SR bank model
module tb_sr_bank_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 6;
  localparam int IDX_W = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ-1:0]       op = '0;
  logic [N_REQ*IDX_W-1:0] idx = '0;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       S;
  logic [WIDTH-1:0]       R;
  logic [WIDTH-1:0]       shadow;
  logic                   busy;
  logic                   err;

  sr_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .S(S), .R(R), .shadow(shadow), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // bank model and the S/R values the bank will sample at the next edge
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] s_prev = '0;
  logic [WIDTH-1:0] r_prev = '0;

  // reference model: expected outputs and command bookkeeping
  logic [N_REQ-1:0] e_gnt;
  logic [WIDTH-1:0] e_S, e_R, e_shadow;
  logic             e_busy, e_err;
  bit               m_init;
  int               m_wait;
  int               m_ptr;
  bit               pend_valid;
  int               pend_idx;
  bit               pend_op;

  int gq[$];
  int gcyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_wait = 0; m_ptr = 0; pend_valid = 1'b0;
    e_gnt = '0; e_S = '0; e_R = '1; e_shadow = '0; e_busy = 1'b1; e_err = 1'b0;
  endtask

  task automatic model_step();
    int w;
    int ix;
    bit o;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_init) begin
      m_init = 1'b0; e_R = '0; e_busy = 1'b0;
    end else if (m_wait == 0) begin
      if (req != 0) begin
        w = -1;
        for (int k = 0; k < N_REQ; k++)
          if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        o = op[w];
        ix = int'(idx[w*IDX_W +: IDX_W]);
        e_gnt = '0; e_gnt[w] = 1'b1; e_busy = 1'b1;
        e_S = '0; e_R = '0; e_err = 1'b0;
        if (ix < WIDTH) begin
          if (o) e_S[ix] = 1'b1; else e_R[ix] = 1'b1;
          pend_valid = 1'b1; pend_idx = ix; pend_op = o;
        end else begin
          e_err = 1'b1; pend_valid = 1'b0;
        end
        m_ptr = (w + 1) % N_REQ;
        m_wait = 2;
      end
    end else if (m_wait == 2) begin
      if (pend_valid) e_shadow[pend_idx] = pend_op;
      e_gnt = '0; e_S = '0; e_R = '0; e_err = 1'b0;
      m_wait = 1;
    end else begin
      e_busy = 1'b0;
      m_wait = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      if (s_prev[i] && !r_prev[i]) bank[i] = 1'b1;
      else if (r_prev[i] && !s_prev[i]) bank[i] = 1'b0;
    end
    model_step();
    cyc++;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("S", 32'(S), 32'(e_S));
    check("R", 32'(R), 32'(e_R));
    check("err", 32'(err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));
    check("shadow", 32'(shadow), 32'(e_shadow));
    check("s_and_r", 32'(S & R), 32'd0);
    if (rst_n && !m_init) begin
      check("bank_q", 32'(bank), 32'(e_shadow));
      check("sr_onehot", 32'($countones(S | R) <= 1), 32'd1);
    end
    if (gnt != 0) begin
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) gq.push_back(i);
      gcyc.push_back(cyc);
    end
    s_prev = S;
    r_prev = R;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    s_prev = S;
    r_prev = R;
    check("rst_R", 32'(R), 32'(6'h3F));
    check("rst_S", 32'(S), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input int r, input bit o, input int ix);
    op[r] = o;
    idx[r*IDX_W +: IDX_W] = IDX_W'(ix);
  endtask

  initial begin
    logic [WIDTH-1:0] saved;
    int budget;

    // reset / INIT
    do_reset(3);
    tick();
    check("init_R", 32'(R), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_bank", 32'(bank), 32'd0);

    // single set on bit 5
    set_cmd(0, 1'b1, 5);
    req = 4'b0001;
    tick();
    check("single_gnt", 32'(gnt), 32'd1);
    check("single_S", 32'(S), 32'h20);
    req = '0;
    tick();
    check("single_shadow", 32'(shadow), 32'h20);
    check("single_q5", 32'(bank[5]), 32'd1);
    tick();
    check("single_idle", 32'(busy), 32'd0);

    // round robin, all requesters continuously requesting
    do_reset(2);
    tick();
    gq.delete(); gcyc.delete();
    for (int i = 0; i < N_REQ; i++) set_cmd(i, 1'b1, i);
    req = 4'b1111;
    budget = 0;
    while (gq.size() < 5 && budget < 40) begin tick(); budget++; end
    check("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), 32'(i % N_REQ));
    for (int i = 1; i < 5 && i < gcyc.size(); i++) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    req = '0;
    repeat (2) tick();
    check("rr_shadow", 32'(shadow), 32'h0F);

    // conflict on bit 2: requester 1 sets, requester 2 resets, ptr starts at 0
    do_reset(2);
    tick();
    gq.delete(); gcyc.delete();
    set_cmd(1, 1'b1, 2);
    set_cmd(2, 1'b0, 2);
    req = 4'b0110;
    budget = 0;
    while ((req != 0 || busy) && budget < 30) begin
      tick();
      if (gnt[1]) req[1] = 1'b0;
      if (gnt[2]) req[2] = 1'b0;
      budget++;
    end
    check("conf_done", 32'(budget < 30), 32'd1);
    check("conf_count", 32'(gq.size()), 32'd2);
    if (gq.size() == 2) begin
      check("conf_first", 32'(gq[0]), 32'd1);
      check("conf_second", 32'(gq[1]), 32'd2);
    end
    check("conf_bit2", 32'(shadow[2]), 32'd0);

    // invalid index on a 6-bit bank
    set_cmd(0, 1'b1, 1);
    req = 4'b0001;
    repeat (4) tick();
    req = '0;
    repeat (3) tick();
    saved = shadow;
    set_cmd(0, 1'b1, 7);
    req = 4'b0001;
    tick();
    check("inv_gnt", 32'(gnt), 32'd1);
    check("inv_err", 32'(err), 32'd1);
    check("inv_S", 32'(S), 32'd0);
    check("inv_R", 32'(R), 32'd0);
    req = '0;
    tick();
    check("inv_err_clr", 32'(err), 32'd0);
    check("inv_shadow", 32'(shadow), 32'(saved));
    tick();

    // reset asserted in the middle of DRIVE of a set on bit 3
    set_cmd(0, 1'b1, 3);
    req = 4'b0001;
    tick();
    check("mid_S", 32'(S), 32'h08);
    req = '0;
    #2;
    do_reset(2);
    tick();
    check("mid_q3", 32'(bank[3]), 32'd0);
    check("mid_shadow", 32'(shadow), 32'd0);

    // randomized traffic, including out-of-range indices
    for (int n = 0; n < 400; n++) begin
      req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      op  = N_REQ'($urandom);
      idx = (N_REQ*IDX_W)'($urandom);
      tick();
    end
    req = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Controller for a shared bank of clocked SR flip-flops (NOR-type, Q/NQ outputs). It accepts set/reset commands from up to N_REQ requesters and grants them in round-robin order. It drives each command to the bank as a single-cycle S or R pulse on exactly one bit, and keeps a shadow copy of the bank contents. By construction it never presents the forbidden S=R=1 combination on any bit. It sits between the lab's requester logic (switch debouncers, FSM blocks) and the SR flip-flop bank.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, number of SR flip-flops in the bank
- IDX_W, 3, bit-index width, must be >= clog2(WIDTH)

- clk  in  1  rising-edge clock, shared with the SR bank
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held high until granted
- op  in  N_REQ  per-requester command: 1 = set, 0 = reset
- idx  in  N_REQ*IDX_W  packed bit index; requester i uses [i*IDX_W +: IDX_W]
- gnt  out  N_REQ  one-hot grant pulse, one cycle
- S  out  WIDTH  set lines to the bank
- R  out  WIDTH  reset lines to the bank
- shadow  out  WIDTH  controller model of bank Q
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse: granted idx >= WIDTH

## Operation
- All outputs are registered. The FSM has four states: INIT, IDLE, DRIVE, HOLD.
- **Reset** (rst_n low, asynchronous):
  - state = INIT, ptr = 0.
  - Output values: R = all ones, S = 0, gnt = 0, shadow = 0, busy = 1, err = 0.
- **INIT:** lasts exactly one cycle after rst_n deasserts. The bank samples R = all ones at that edge, which makes the bank agree with shadow = 0. Next state is IDLE, with R <= 0 and busy <= 0.
- **IDLE:**
  - If no req bit is set, remain in IDLE.
  - Otherwise the winner is the first set req bit searching from ptr upward, wrapping modulo N_REQ.
  - Latch the winner's op and idx.
  - Set gnt[winner] <= 1 and busy <= 1.
  - If idx < WIDTH: S[idx] <= op and R[idx] <= ~op. Else: S = R = 0 and err <= 1.
  - ptr <= (winner+1) mod N_REQ.
  - Next state is DRIVE.
- **DRIVE:**
  - At the edge ending DRIVE, the bank samples the S/R pulse.
  - If idx is valid, shadow[idx] <= op.
  - Clear gnt, S, R and err to 0.
  - Next state is HOLD.
- **HOLD:** a one-cycle guard with S = R = 0. Next state is IDLE; busy <= 0.
- req is ignored in INIT, DRIVE and HOLD.
- Redundant commands (shadow[idx] already equal to op) are still driven. They are harmless.
- Invariant: S & R == 0 in every cycle except INIT, where S = 0. At most one bit of S|R is high outside INIT.
- Two requesters targeting the same bit with opposite ops are serialized in round-robin order. The later command wins in shadow.

## Timing
- Edge e0 (state IDLE, req sampled): gnt, S, R and err become visible in the DRIVE cycle.
- Edge e1: the bank Q updates and shadow updates. Both are visible in the HOLD cycle.
- Edge e2: return to IDLE. The next arbitration happens at e3.
- Maximum throughput is one command per 3 cycles. Latency from a req sampled in IDLE to the bank Q updating is 2 edges.
- Requester rule: drop req (or present a new command) no later than the edge ending HOLD. A req still high in IDLE is treated as a new request.
- Reset asserted mid-DRIVE:
  - Outputs take their reset values immediately.
  - The in-flight command is lost and shadow is cleared.
  - INIT then re-clears the bank.
- Fairness: with all requesters continuously requesting, each is granted once every N_REQ commands.

## Test plan
- **Reset/INIT:** hold rst_n low for 3 cycles, then release.
  - During reset: R = 8'hFF, busy = 1.
  - After one cycle: R = 0, busy = 0, shadow = 0.
  - Bank Q = 8'h00.
- **Single set:** req = 4'b0001, op[0] = 1, idx0 = 5.
  - DRIVE cycle: gnt = 4'b0001, S = 8'h20, R = 0.
  - HOLD cycle: shadow = 8'h20 and bank Q[5] = 1.
  - Back in IDLE 3 cycles after e0.
- **Round robin:** all four requesters held high, each with op = 1 and idx = i.
  - Grants occur in order 0, 1, 2, 3, 0, spaced 3 cycles apart.
  - shadow reaches 8'h0F after the 4th grant.
- **Conflict:** requester 1 sets bit 2, requester 2 resets bit 2, both raised in the same cycle with ptr = 0.
  - gnt order is 1 then 2; final shadow[2] = 0.
  - S & R == 0 checked on every cycle.
- **Invalid index:** WIDTH = 6, idx = 7.
  - gnt pulses, err = 1 for one cycle, S = R = 0.
  - shadow is unchanged.
- **Reset mid-op:** assert rst_n low during DRIVE of a set on bit 3.
  - Outputs take reset values immediately; shadow = 0.
  - After release, INIT clears the bank and Q[3] = 0.
